// File: rtl/fetch_issue_queue.sv
// ============================================================================
// Module   : fetch_issue_queue
// Brief    : Sequential instruction fetch into a small FIFO feeding issue.
//            Optional flush/redirect is built when FIQ_REDIRECT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_issue_queue #(
    parameter int DEPTH    = 4,
    parameter int MEM_SIZE = 128
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        isend,
    output logic        issue_valid,
    output logic [31:0] issue_instr,
    output logic [31:0] issue_pc,
    output logic        issue_end,
    input  logic        issue_ready,
`ifdef FIQ_REDIRECT_EN
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`endif
    output logic        halted
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
    localparam logic [31:0]     c_LAST  = 32'(MEM_SIZE - 1);

    localparam logic [1:0] c_FETCH   = 2'd0;
    localparam logic [1:0] c_ENDSEEN = 2'd1;
    localparam logic [1:0] c_DONE    = 2'd2;

    // Entry layout: {end, pc, instr}
    logic [64:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_rd;
    logic [c_AW-1:0] r_wr;
    logic [c_CW-1:0] r_count;
    logic [31:0]     r_pc;
    logic [1:0]      r_state;

    logic [64:0]     w_head;
    logic            w_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_redir;
    logic            w_do_pop;
    logic            w_do_push;
    logic [31:0]     w_pc_inc;
    logic [31:0]     w_pc_n;
    logic [1:0]      w_state_n;

    assign w_head  = r_mem[r_rd];
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && issue_ready;
    assign w_push  = (r_state == c_FETCH) && ((r_count < c_DEPTH) || w_pop);

`ifdef FIQ_REDIRECT_EN
    assign w_redir = redirect_valid && (r_state != c_DONE);
`else
    assign w_redir = 1'b0;
`endif

    // A redirect overrides any push or pop in the same cycle
    assign w_do_pop  = w_pop && !w_redir;
    assign w_do_push = w_push && !w_redir;
    assign w_pc_inc  = (r_pc == c_LAST) ? 32'd0 : r_pc + 32'd1;

    always_comb begin
        w_pc_n    = r_pc;
        w_state_n = r_state;
        if (w_do_push) begin
            w_pc_n = w_pc_inc;
        end
        case (r_state)
            c_FETCH: begin
                if (w_do_push && isend) begin
                    w_state_n = c_ENDSEEN;
                    w_pc_n    = r_pc;
                end
            end
            c_ENDSEEN: begin
                if (w_do_pop && w_head[64]) begin
                    w_state_n = c_DONE;
                end
            end
            c_DONE: begin
                w_state_n = c_DONE;
            end
            default: begin
                w_state_n = c_FETCH;
            end
        endcase
`ifdef FIQ_REDIRECT_EN
        if (w_redir) begin
            w_pc_n    = redirect_pc;
            w_state_n = c_FETCH;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= 32'd0;
            r_state <= c_FETCH;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_pc    <= w_pc_n;
            r_state <= w_state_n;
            if (w_redir) begin
                r_rd    <= '0;
                r_wr    <= '0;
                r_count <= '0;
            end else begin
                if (w_do_pop) begin
                    r_rd <= r_rd + c_AW'(1);
                end
                if (w_do_push) begin
                    r_wr <= r_wr + c_AW'(1);
                end
                case ({w_do_push, w_do_pop})
                    2'b10:   r_count <= r_count + c_CW'(1);
                    2'b01:   r_count <= r_count - c_CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_do_push) begin
            r_mem[r_wr] <= {isend, r_pc, instr};
        end
    end

    assign pc          = r_pc;
    assign halted      = (r_state == c_DONE);
    assign issue_valid = w_valid;
    assign issue_end   = w_valid ? w_head[64]    : 1'b0;
    assign issue_pc    = w_valid ? w_head[63:32] : 32'd0;
    assign issue_instr = w_valid ? w_head[31:0]  : 32'd0;

endmodule

`default_nettype wire

// File: doc/fetch_issue_queue.md
# fetch_issue_queue

Fetch-side consumer of the combinational instruction memory: drives the word-addressed program counter, captures the returned instruction word and its end-of-program flag, and buffers them in a small FIFO. The FIFO feeds the Tomasulo issue stage through a valid/ready handshake. The block stops fetching once the end instruction (opcode `6'b111111`) is seen and raises `halted` after the issue stage consumes it.

## Interface
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `MEM_SIZE`, 128: instruction memory words; `pc` wraps to 0 after `MEM_SIZE-1`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `pc` output 32: word address presented to instruction memory.
- `instr` input 32: instruction word for the current `pc`, valid in the same cycle.
- `isend` input 1: end-of-program flag for the current `pc`, valid in the same cycle.
- `issue_valid` output 1: queue head is valid.
- `issue_instr` output 32: head instruction.
- `issue_pc` output 32: head instruction address.
- `issue_end` output 1: head is the end instruction.
- `issue_ready` input 1: issue stage accepts the head this cycle.
- `redirect_valid` input 1: flush and restart fetch. Present only with `FIQ_REDIRECT_EN`.
- `redirect_pc` input 32: restart address. Present only with `FIQ_REDIRECT_EN`.
- `halted` output 1: the end instruction has been issued and the block is idle.

## Operation
- Entry format: `{end, pc, instr}`, 65 bits. Occupancy counter is `$clog2(DEPTH)+1` bits wide. Read and write pointers wrap modulo `DEPTH`.
- **State machine:** FETCH, ENDSEEN, DONE.
- **FETCH:**
  - Push `{isend, pc, instr}` when `count < DEPTH`, or when `count == DEPTH` and a pop occurs in the same cycle.
  - On push, advance `pc`: `pc + 1`, or 0 if `pc == MEM_SIZE-1`.
  - If the pushed entry has `isend=1`: go to ENDSEEN and hold `pc`.
  - No push: `pc` holds.
- **ENDSEEN:**
  - No pushes; `pc` holds.
  - A pop of an entry with `end=1` moves to DONE.
- **DONE:**
  - `halted=1`, queue empty, no fetch.
  - Terminal until `rst`; redirect is ignored.
- **Pop:** occurs when `issue_valid && issue_ready`. `issue_*` outputs are driven combinationally from the head entry. When the queue is empty, `issue_valid=0` and the other `issue_*` outputs are 0.
- **Simultaneous push and pop:** both happen and `count` is unchanged, including when the queue is full or holds one entry.
- **Redirect** (FETCH or ENDSEEN), which has priority over push and pop in the same cycle:
  - Pointers and count are cleared; any pop that cycle is discarded.
  - `pc <= redirect_pc`, state becomes FETCH.
- **Out-of-range `redirect_pc`:** if `redirect_pc >= MEM_SIZE`, it is loaded unchanged. Wrap applies only on increment.
- **Reset:** `pc=0`, queue empty, state FETCH, `issue_valid=0`, `issue_instr=0`, `issue_pc=0`, `issue_end=0`, `halted=0`. Reset mid-operation discards all entries immediately.

## Timing
- **Fetch:** `pc` is registered; `instr` and `isend` are sampled at the same edge that advances `pc`. One push per cycle maximum, so peak throughput is one instruction per clock.
- **Fetch-to-issue latency:** the instruction at address A appears on `issue_*` in the cycle after `pc==A` is sampled, if the queue was empty.
- **First push:** occurs on the first edge with `rst=0`, so the first entry (address 0) is visible one cycle after reset deasserts.
- **Halt:** `halted` rises the cycle after the edge that pops the end entry.
- **Redirect:** in the cycle after `redirect_valid`, `pc == redirect_pc` and `issue_valid=0`. The new instruction is issued one cycle later.
- **Backpressure:** `issue_ready` low for N cycles with a full queue stalls `pc` for those N cycles. No entry is lost or duplicated.

## Configuration
- `FIQ_REDIRECT_EN` defined: `redirect_valid` and `redirect_pc` ports exist, and flush/redirect behaves as above.
- Undefined: those ports are absent, the redirect logic is not built, and fetch is strictly sequential. ENDSEEN can only exit to DONE.

## Test plan
- **Sequential fetch:**
  - Memory holds addresses 0..5 as ADD, with address 6 `isend`; `issue_ready=1` throughout.
  - Required: `issue_pc` shows 0..6 on consecutive cycles and `issue_end=1` at pc 6.
  - Required: `halted=1` the cycle after the pc-6 pop, and `pc` stays at 6.
- **Backpressure:**
  - `issue_ready=0` for 10 cycles from reset, with `DEPTH=4`.
  - Required: `count` saturates at 4 and `pc` holds at 4.
  - Required: after release, entries 0,1,2,3,4,5 issue in order with no gaps.
- **Full with simultaneous push/pop:**
  - Queue full, `issue_ready=1` for one cycle.
  - Required: `count` stays 4 and `pc` advances by 1.
- **Redirect** (macro on):
  - In ENDSEEN with 3 entries queued, assert `redirect_valid` with `redirect_pc=20` and `issue_ready=1`.
  - Required: no pop; next cycle `issue_valid=0`, `pc=20`, state FETCH.
  - Required: the next cycle issues pc 20.
- **Wrap:**
  - `MEM_SIZE=8`, no end instruction in memory.
  - Required: `pc` sequence 6, 7, 0, 1.
- **Reset mid-operation:**
  - Assert `rst` for one cycle with 2 entries queued at `pc=9`.
  - Required: next cycle `pc=0`, `issue_valid=0`, `halted=0`.
  - Required: fetch resumes from 0.
